// File: rtl/hazard_ctrl_mc.sv
// Hazard/interlock unit for the 5-stage pipeline.
// Interlocks, forwarding, mul/div busy tracking and memory-wait freeze.
// Optional stall-cause counters are built when HAZARD_PERF_EN is defined.
// Ports:
//   clk, resetn (async, active low)
//   stage valids and ID/EX/MEM/WB register fields and controls (inputs)
//   mem_ack, exc_flush, perf_clr (inputs)
//   stage stalls, ex/wb flush, ID/EX forward selects (outputs)
//   md_busy and perf_* counters (outputs)
module hazard_ctrl_mc #(
  parameter int AW     = 5,
  parameter int LAT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              mem_valid,
  input  logic              wb_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_use_hilo,
  input  logic [AW-1:0]     ex_rs,
  input  logic [AW-1:0]     ex_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic [AW-1:0]     ex_waddr,
  input  logic              ex_md_start,
  input  logic [LAT_W-1:0]  ex_md_lat,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic              mem_req,
  input  logic [AW-1:0]     mem_waddr,
  input  logic              mem_ack,
  input  logic              wb_regwrite,
  input  logic [AW-1:0]     wb_waddr,
  input  logic              exc_flush,
  input  logic              perf_clr,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              ex_flush,
  output logic              wb_flush,
  output logic              id_fwd1,
  output logic              id_fwd2,
  output logic [1:0]        ex_fwd1,
  output logic [1:0]        ex_fwd2,
  output logic              md_busy,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_md,
  output logic [PERF_W-1:0] perf_mem
);

  function automatic logic hit(
    input logic [AW-1:0] a,
    input logic [AW-1:0] w
  );
    return (a != '0) && (a == w);
  endfunction

  logic [LAT_W-1:0] md_cnt;
  logic             ex_src_hit;
  logic             mem_src_hit;
  logic             lu_stall;
  logic             br_stall;
  logic             md_pend;
  logic             md_stall;
  logic             mem_wait;
  logic             interlock;
  logic             md_accept;

  assign ex_src_hit  = (id_use_rs && hit(id_rs, ex_waddr))
                    || (id_use_rt && hit(id_rt, ex_waddr));
  assign mem_src_hit = (id_use_rs && hit(id_rs, mem_waddr))
                    || (id_use_rt && hit(id_rt, mem_waddr));

  assign lu_stall = id_valid && ex_valid && ex_regwrite
                 && ex_memtoreg && ex_src_hit;
  assign br_stall = id_valid && id_branch
                 && ((ex_valid && ex_regwrite && ex_src_hit)
                  || (mem_valid && mem_memtoreg && mem_src_hit));
  assign md_pend  = md_busy
                 || (ex_valid && ex_md_start && ex_md_lat != '0);
  assign md_stall = id_valid && id_use_hilo && md_pend;
  assign mem_wait = mem_valid && mem_req && !mem_ack;

  assign interlock = lu_stall || br_stall || md_stall;

  // Memory freeze holds the whole pipe and swallows any ID interlock.
  assign if_stall  = mem_wait || interlock;
  assign id_stall  = mem_wait || interlock;
  assign ex_stall  = mem_wait;
  assign mem_stall = mem_wait;
  assign wb_flush  = mem_wait;
  assign ex_flush  = exc_flush || (!mem_wait && interlock);

  assign id_fwd1 = id_valid && mem_valid && mem_regwrite
                && !mem_memtoreg && hit(id_rs, mem_waddr);
  assign id_fwd2 = id_valid && mem_valid && mem_regwrite
                && !mem_memtoreg && hit(id_rt, mem_waddr);

  always_comb begin
    ex_fwd1 = 2'b00;
    ex_fwd2 = 2'b00;
    if (ex_valid && mem_valid && mem_regwrite && hit(ex_rs, mem_waddr))
      ex_fwd1 = 2'b10;
    else if (ex_valid && wb_valid && wb_regwrite && hit(ex_rs, wb_waddr))
      ex_fwd1 = 2'b01;
    if (ex_valid && mem_valid && mem_regwrite && hit(ex_rt, mem_waddr))
      ex_fwd2 = 2'b10;
    else if (ex_valid && wb_valid && wb_regwrite && hit(ex_rt, wb_waddr))
      ex_fwd2 = 2'b01;
  end

  assign md_accept = ex_valid && ex_md_start && !ex_stall
                  && !exc_flush && ex_md_lat != '0;

  // Counter keeps draining during a freeze; the unit runs on its own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      md_cnt <= '0;
    else if (md_accept)
      md_cnt <= ex_md_lat;
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  assign md_busy = (md_cnt != '0);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] lu_q, br_q, md_q, mem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lu_q  <= '0;
      br_q  <= '0;
      md_q  <= '0;
      mem_q <= '0;
    end else if (perf_clr) begin
      lu_q  <= '0;
      br_q  <= '0;
      md_q  <= '0;
      mem_q <= '0;
    end else begin
      if (!mem_wait && lu_stall) lu_q <= lu_q + 1'b1;
      if (!mem_wait && br_stall) br_q <= br_q + 1'b1;
      if (!mem_wait && md_stall) md_q <= md_q + 1'b1;
      if (mem_wait)              mem_q <= mem_q + 1'b1;
    end
  end

  assign perf_lu  = lu_q;
  assign perf_br  = br_q;
  assign perf_md  = md_q;
  assign perf_mem = mem_q;
`else
  logic unused_perf;
  assign unused_perf = perf_clr;
  assign perf_lu  = '0;
  assign perf_br  = '0;
  assign perf_md  = '0;
  assign perf_mem = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed-vector bench for hazard_ctrl_mc.
// Checks interlocks, forwarding, mul/div tracking, freeze and counters.
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  logic resetn;
  logic id_valid, ex_valid, mem_valid, wb_valid;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
  logic id_use_rs, id_use_rt, id_branch, id_use_hilo;
  logic ex_regwrite, ex_memtoreg, ex_md_start;
  logic [4:0] ex_waddr, mem_waddr, wb_waddr;
  logic [5:0] ex_md_lat;
  logic mem_regwrite, mem_memtoreg, mem_req, mem_ack;
  logic wb_regwrite, exc_flush, perf_clr;
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic ex_flush, wb_flush, id_fwd1, id_fwd2;
  logic [1:0] ex_fwd1, ex_fwd2;
  logic md_busy;
  logic [31:0] perf_lu, perf_br, perf_md, perf_mem;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .ex_valid(ex_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_use_hilo(id_use_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_waddr(ex_waddr), .ex_md_start(ex_md_start),
    .ex_md_lat(ex_md_lat),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_req(mem_req), .mem_waddr(mem_waddr), .mem_ack(mem_ack),
    .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr),
    .exc_flush(exc_flush), .perf_clr(perf_clr),
    .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall),
    .ex_flush(ex_flush), .wb_flush(wb_flush),
    .id_fwd1(id_fwd1), .id_fwd2(id_fwd2),
    .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2),
    .md_busy(md_busy),
    .perf_lu(perf_lu), .perf_br(perf_br),
    .perf_md(perf_md), .perf_mem(perf_mem)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // {if, id, ex, mem, ex_flush, wb_flush}
  function automatic logic [31:0] hz();
    return {26'd0, if_stall, id_stall, ex_stall,
            mem_stall, ex_flush, wb_flush};
  endfunction

  task automatic idle();
    id_valid = 0; ex_valid = 0; mem_valid = 0; wb_valid = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_use_hilo = 0;
    ex_regwrite = 0; ex_memtoreg = 0; ex_md_start = 0;
    ex_waddr = 0; mem_waddr = 0; wb_waddr = 0; ex_md_lat = 0;
    mem_regwrite = 0; mem_memtoreg = 0; mem_req = 0; mem_ack = 0;
    wb_regwrite = 0; exc_flush = 0; perf_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_on();
    id_valid = 1; id_rs = 8; id_use_rs = 1;
    ex_valid = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_waddr = 8;
  endtask

  int st_cnt, bz_cnt;

  initial begin
    idle();
    resetn = 0;
    #12;
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_perf_lu", perf_lu, 0);
    chk("rst_perf_mem", perf_mem, 0);
    resetn = 1;
    @(negedge clk);

    // load-use
    lu_on();
    #1 chk("lu_stall", hz(), 32'b110010);
    id_use_rs = 0;
    #1 chk("lu_unused_rs", hz(), 0);

    // branch against ALU result in EX, then forwarded from MEM
    idle();
    id_valid = 1; id_branch = 1; id_rs = 9; id_use_rs = 1;
    ex_valid = 1; ex_regwrite = 1; ex_waddr = 9;
    #1 chk("br_stall", hz(), 32'b110010);
    ex_valid = 0; ex_regwrite = 0; ex_waddr = 0;
    mem_valid = 1; mem_regwrite = 1; mem_waddr = 9;
    #1 chk("br_mem_nostall", hz(), 0);
    chk("br_id_fwd1", 32'(id_fwd1), 1);
    id_rs = 0; mem_waddr = 0;
    ex_valid = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_waddr = 0;
    #1 chk("r0_nostall", hz(), 0);
    chk("r0_nofwd", 32'(id_fwd1), 0);

    // EX forwarding priority
    idle();
    ex_valid = 1; ex_rs = 4; ex_rt = 4;
    mem_valid = 1; mem_regwrite = 1; mem_waddr = 4;
    wb_valid = 1; wb_regwrite = 1; wb_waddr = 4;
    #1 chk("exfwd_mem", 32'(ex_fwd1), 32'b10);
    chk("exfwd2_mem", 32'(ex_fwd2), 32'b10);
    mem_regwrite = 0;
    #1 chk("exfwd_wb", 32'(ex_fwd1), 32'b01);
    ex_rs = 0;
    #1 chk("exfwd_r0", 32'(ex_fwd1), 32'b00);

    // mul/div: accept lat=5 with mflo waiting in ID
    idle();
    @(negedge clk);
    id_valid = 1; id_use_hilo = 1;
    ex_valid = 1; ex_md_start = 1; ex_md_lat = 5;
    #1 chk("md_accept_stall", 32'(id_stall), 1);
    chk("md_accept_busy", 32'(md_busy), 0);
    st_cnt = 1; bz_cnt = 0;
    tick();
    ex_valid = 0; ex_md_start = 0; ex_md_lat = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (id_stall) st_cnt++;
      if (md_busy) bz_cnt++;
      tick();
    end
    chk("md_stall_cycles", st_cnt, 6);
    chk("md_busy_cycles", bz_cnt, 5);

    // exception flush cancels the issue
    idle();
    ex_valid = 1; ex_md_start = 1; ex_md_lat = 5; exc_flush = 1;
    #1 chk("exc_ex_flush", 32'(ex_flush), 1);
    tick();
    chk("exc_md_cancel", 32'(md_busy), 0);

    // freeze: start mul/div, clear counters, then 3 wait cycles
    idle();
    perf_clr = 1;
    ex_valid = 1; ex_md_start = 1; ex_md_lat = 5;
    tick();
    chk("perf_clr_mem", perf_mem, 0);
    idle();
    lu_on();
    mem_valid = 1; mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("freeze_vec", hz(), 32'b111101);
      tick();
    end
    chk("freeze_md_busy", 32'(md_busy), 1);
    chk("freeze_perf_lu", perf_lu, 0);
`ifdef HAZARD_PERF_EN
    chk("freeze_perf_mem", perf_mem, 3);
`else
    chk("freeze_perf_mem", perf_mem, 0);
`endif
    mem_ack = 1;
    #1 chk("unfreeze_lu", hz(), 32'b110010);
    tick();
`ifdef HAZARD_PERF_EN
    chk("perf_lu_one", perf_lu, 1);
    chk("perf_mem_hold", perf_mem, 3);
`else
    chk("perf_lu_off", perf_lu, 0);
`endif
    chk("md_cnt_one", 32'(md_busy), 1);
    idle();
    tick();
    chk("md_drained", 32'(md_busy), 0);

    // perf_clr then async reset mid-count
    lu_on();
    tick();
    tick();
`ifdef HAZARD_PERF_EN
    chk("perf_lu_count", perf_lu, 3);
`endif
    perf_clr = 1;
    tick();
    chk("perf_clr_lu", perf_lu, 0);
    perf_clr = 0;
    idle();
    lu_on();
    ex_md_start = 1; ex_md_lat = 7; ex_memtoreg = 0; ex_regwrite = 0;
    id_use_hilo = 1;
    tick();
    chk("pre_rst_busy", 32'(md_busy), 1);
`ifdef HAZARD_PERF_EN
    chk("pre_rst_perf_md", perf_md, 1);
`endif
    #2 resetn = 0;
    #1 chk("async_md_busy", 32'(md_busy), 0);
    chk("async_perf_md", perf_md, 0);
    chk("async_perf_lu", perf_lu, 0);
    resetn = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
